// File: rtl/fir_arb_pkg.sv
// fir_arb_pkg: shared types and constants for the two-requester FIR engine
// arbiter.
//   NREQ        - number of requesters (fixed at 2)
//   DW_DEF      - default sample width
//   TIMEOUT_DEF - default watchdog limit (used only with FIR_ARB_TIMEOUT_EN)
//   state_e     - arbiter FSM states
package fir_arb_pkg;

  localparam int NREQ        = 2;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin winner select with its priority pointer.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (pointer -> requester 0)
//   req        - pending requests
//   grant      - high on the cycle the winner is actually granted
//   win        - index of the selected requester (valid when req != 0)
module rr_arb2
  import fir_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            grant,
  output logic            win
);

  logic ptr_q;

  // The pointer only breaks ties, so a lone requester wins without moving it.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ptr_q;
    end else if (req[1]) begin
      win = 1'b1;
    end
  end

  // After a contested grant the loser gets priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (grant && (req == 2'b11)) begin
      ptr_q <= ~win;
    end
  end

endmodule

// File: rtl/fir_arbiter.sv
// fir_arbiter: shares one FIR engine between two requesters.
// Each requester has a one-deep pending slot; a round-robin pick issues one
// transaction at a time to the engine and routes the result back.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_go[1:0]           - per-requester start pulse
//   req_data0, req_data1  - operands captured with req_go
//   req_done[1:0]         - per-requester completion pulse
//   req_out               - result, valid with req_done
//   eng_go, eng_data      - engine start pulse and held operand
//   eng_done, eng_out     - engine completion and result
//   busy                  - a transaction is outstanding
//   ovr_err[1:0]          - sticky: req_go while that requester still pending
// Optional feature (macro FIR_ARB_TIMEOUT_EN): an 8-bit watchdog abandons a
// transaction after TIMEOUT cycles, returning 0 and setting sticky
// timeout_err.
module fir_arbiter
  import fir_arb_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_go,
  input  logic signed [DW-1:0]   req_data0,
  input  logic signed [DW-1:0]   req_data1,
  output logic [NREQ-1:0]        req_done,
  output logic signed [DW-1:0]   req_out,
  output logic                   eng_go,
  output logic signed [DW-1:0]   eng_data,
  input  logic                   eng_done,
  input  logic signed [DW-1:0]   eng_out,
  output logic                   busy,
  output logic [NREQ-1:0]        ovr_err
`ifdef FIR_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fir_arbiter: TIMEOUT must lie in 2..255");
  end

  state_e                state_q, state_d;
  logic [NREQ-1:0]       pend_q, pend_d;
  logic [NREQ-1:0]       clr, cap, ovr_set;
  logic signed [DW-1:0]  data0_q, data1_q;
  logic                  cur_q;
  logic                  grant, fin, fin_to, win;
  logic                  eng_go_q;
  logic signed [DW-1:0]  eng_data_q, req_out_q;
  logic [NREQ-1:0]       req_done_q, ovr_q;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (pend_q),
    .grant (grant),
    .win   (win)
  );

`ifdef FIR_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  logic [7:0] wdog_q;
  logic [7:0] wdog_nxt;
  logic       timeout_q;
  assign wdog_nxt = wdog_q + 8'd1;
`endif

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    fin     = 1'b0;
    fin_to  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // eng_done is deliberately not looked at here.
        if (|pend_q) begin
          grant   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
`ifdef FIR_ARB_TIMEOUT_EN
        else if (wdog_nxt == TO_LIM) begin
          fin     = 1'b1;
          fin_to  = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new req_go on the completing edge re-arms the slot instead of
  // counting as an overrun, because the old request is retiring right now.
  always_comb begin
    clr     = fin ? (cur_q ? 2'b10 : 2'b01) : 2'b00;
    cap     = req_go & (~pend_q | clr);
    ovr_set = req_go & pend_q & ~clr;
    pend_d  = (pend_q & ~clr) | req_go;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      cur_q      <= 1'b0;
      eng_go_q   <= 1'b0;
      eng_data_q <= '0;
      req_done_q <= '0;
      req_out_q  <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      eng_go_q   <= grant;
      req_done_q <= clr;
      ovr_q      <= ovr_q | ovr_set;
      if (grant) begin
        eng_data_q <= win ? data1_q : data0_q;
        cur_q      <= win;
      end
      if (fin) begin
        req_out_q <= fin_to ? '0 : eng_out;
      end
    end
  end

  // Operand slots are pure data; their contents only matter while pending.
  always_ff @(posedge clk) begin
    if (cap[0]) data0_q <= req_data0;
    if (cap[1]) data1_q <= req_data1;
  end

`ifdef FIR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (grant) begin
        wdog_q <= '0;
      end else if (state_q == S_WAIT) begin
        wdog_q <= wdog_nxt;
      end
      if (fin_to) timeout_q <= 1'b1;
    end
  end
  assign timeout_err = timeout_q;
`endif

  assign req_done = req_done_q;
  assign req_out  = req_out_q;
  assign eng_go   = eng_go_q;
  assign eng_data = eng_data_q;
  assign busy     = (state_q == S_WAIT);
  assign ovr_err  = ovr_q;

endmodule

// File: tb/tb_fir_arbiter.sv
// tb_fir_arbiter: scoreboard bench for fir_arbiter. A transaction-level
// model of the arbitration rules predicts grants and completions; a
// negedge monitor compares the DUT against the queued expectations.
module tb_fir_arbiter;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_go;
  logic [DW-1:0] req_data0, req_data1;
  logic [1:0]    req_done;
  logic [DW-1:0] req_out;
  logic          eng_go;
  logic [DW-1:0] eng_data;
  logic          eng_done;
  logic [DW-1:0] eng_out;
  logic          busy;
  logic [1:0]    ovr_err;
`ifdef FIR_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  fir_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_go    (req_go),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_done  (req_done),
    .req_out   (req_out),
    .eng_go    (eng_go),
    .eng_data  (eng_data),
    .eng_done  (eng_done),
    .eng_out   (eng_out),
    .busy      (busy),
    .ovr_err   (ovr_err)
`ifdef FIR_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  typedef struct { int cyc; logic [DW-1:0] data; } go_t;
  typedef struct { int cyc; logic id; logic [DW-1:0] out; } done_t;

  go_t   go_q[$];
  done_t done_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit started = 0;

  // Reference state: one slot per requester, a tie-break pointer and the
  // single outstanding engine transaction.
  logic [1:0]    m_pend;
  logic [DW-1:0] m_data [2];
  bit            m_busy, m_cur, m_ptr, m_to_err;
  logic [1:0]    m_ovr;
  logic [DW-1:0] m_gdata, m_eout;
  int            m_done_at, m_grant_at;

  int            lat_ovr = 0;
  bit            eout_ovr_en = 0;
  logic [DW-1:0] eout_ovr = '0;
  bit            force_idle_done = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic model_reset();
    m_pend = '0; m_data[0] = '0; m_data[1] = '0;
    m_busy = 0; m_cur = 0; m_ptr = 0; m_to_err = 0; m_ovr = '0;
    m_gdata = '0; m_eout = '0; m_done_at = -1; m_grant_at = 0;
    go_q.delete(); done_q.delete();
  endtask

  task automatic model_edge(input logic [1:0] g, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic ed);
    logic [1:0] clr;
    bit w;
    go_t gi;
    done_t di;
    clr = '0;
    if (m_busy) begin
      if (ed) begin
        di.cyc = cyc; di.id = m_cur; di.out = m_eout;
        done_q.push_back(di);
        clr[m_cur] = 1'b1;
        m_busy = 0;
      end
`ifdef FIR_ARB_TIMEOUT_EN
      else if (cyc - m_grant_at == TO) begin
        di.cyc = cyc; di.id = m_cur; di.out = '0;
        done_q.push_back(di);
        clr[m_cur] = 1'b1;
        m_busy = 0;
        m_to_err = 1;
      end
`endif
    end else if (m_pend != 2'b00) begin
      if (m_pend == 2'b11) begin
        w = m_ptr;
        m_ptr = !w;
      end else begin
        w = m_pend[1];
      end
      m_busy = 1; m_cur = w; m_gdata = m_data[w]; m_grant_at = cyc;
      m_done_at = cyc + ((lat_ovr != 0) ? lat_ovr : int'($urandom_range(1, 4)));
      m_eout = eout_ovr_en ? eout_ovr : DW'($urandom);
      gi.cyc = cyc; gi.data = m_data[w];
      go_q.push_back(gi);
    end
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) m_pend[i] = 1'b0;
      if (g[i]) begin
        if (m_pend[i]) begin
          m_ovr[i] = 1'b1;
        end else begin
          m_pend[i] = 1'b1;
          m_data[i] = (i == 1) ? d1 : d0;
        end
      end
    end
  endtask

  // One clock: drive requests plus the engine's response, then advance.
  task automatic step(input logic [1:0] g, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic          ed;
    logic [DW-1:0] eo;
    ed = m_busy && (cyc + 1 == m_done_at);
    eo = ed ? m_eout : DW'($urandom);
    if (!m_busy && (force_idle_done || $urandom_range(0, 7) == 0)) ed = 1'b1;
    req_go = g; req_data0 = d0; req_data1 = d1;
    eng_done = ed; eng_out = eo;
    @(posedge clk);
    cyc++;
    model_edge(g, d0, d1, ed);
    #1;
    req_go = '0;
    eng_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(2'b00, DW'($urandom), DW'($urandom));
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (eng_go) begin
        if (go_q.size() == 0) begin
          chk("eng_go_unexpected", eng_go, 1'b0);
        end else begin
          go_t e;
          e = go_q.pop_front();
          chk("eng_go_cycle", cyc, e.cyc);
          chk("eng_data_at_go", eng_data, e.data);
        end
      end else if (go_q.size() > 0 && go_q[0].cyc <= cyc) begin
        void'(go_q.pop_front());
        chk("eng_go_missing", eng_go, 1'b1);
      end

      if (req_done != 2'b00) begin
        if (done_q.size() == 0) begin
          chk("req_done_unexpected", req_done, 2'b00);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("req_done_cycle", cyc, e.cyc);
          chk("req_done_id", req_done, e.id ? 2'b10 : 2'b01);
          chk("req_out", req_out, e.out);
        end
      end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
        void'(done_q.pop_front());
        chk("req_done_missing", req_done, 2'b01);
      end

      chk("busy", busy, m_busy);
      chk("ovr_err", ovr_err, m_ovr);
      if (m_busy) chk("eng_data_hold", eng_data, m_gdata);
`ifdef FIR_ARB_TIMEOUT_EN
      chk("timeout_err", timeout_err, m_to_err);
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_done"}, req_done, 2'b00);
    chk({tag, "_req_out"}, req_out, '0);
    chk({tag, "_eng_go"}, eng_go, 1'b0);
    chk({tag, "_eng_data"}, eng_data, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ovr_err"}, ovr_err, 2'b00);
`ifdef FIR_ARB_TIMEOUT_EN
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    req_go = '0; req_data0 = '0; req_data1 = '0;
    eng_done = 1'b0; eng_out = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    started = 1;

    // Single request, engine answers three cycles after eng_go.
    lat_ovr = 3; eout_ovr_en = 1; eout_ovr = 32'h0000_5678;
    step(2'b01, 32'h0000_1234, 32'h0);
    idle(8);
    eout_ovr_en = 0;

    // Reset while waiting on the engine; a late eng_done must be ignored.
    lat_ovr = 1000;
    step(2'b01, 32'h0000_0BAD, 32'h0);
    idle(2);
    chk("busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_ovr = 0;
    force_idle_done = 1;
    step(2'b00, 32'h0, 32'h0);
    force_idle_done = 0;
    idle(3);

    // Simultaneous pairs: requester 0 first after reset, then 1 first.
    step(2'b11, 32'h0000_0100, 32'h0000_0101);
    idle(14);
    step(2'b11, 32'h0000_0200, 32'h0000_0201);
    idle(14);

    // Overrun on requester 1 while the engine is busy with requester 0.
    lat_ovr = 4;
    step(2'b01, 32'h0000_0005, 32'h0);
    idle(1);
    step(2'b10, 32'h0, 32'h0000_000A);
    step(2'b10, 32'h0, 32'h0000_000B);
    chk("overrun_flag", ovr_err, 2'b10);
    lat_ovr = 0;
    idle(16);

    // Same-edge re-request on the completing edge of requester 0.
    lat_ovr = 2;
    step(2'b01, 32'h0000_0011, 32'h0);
    for (int k = 0; k < 20 && !(m_busy && cyc + 1 == m_done_at); k++) idle(1);
    step(2'b01, 32'h0000_0022, 32'h0);
    chk("same_edge_no_ovr", ovr_err[0], 1'b0);
    idle(8);
    lat_ovr = 0;

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [1:0] g;
      g[0] = ($urandom_range(0, 3) == 0);
      g[1] = ($urandom_range(0, 3) == 0);
      step(g, DW'($urandom), DW'($urandom));
    end

`ifdef FIR_ARB_TIMEOUT_EN
    for (int k = 0; k < 60 && (m_busy || m_pend != 2'b00); k++) idle(1);
    lat_ovr = 1000;
    step(2'b01, 32'h0000_0077, 32'h0);
    idle(TO + 3);
    chk("timeout_sticky", timeout_err, 1'b1);
    lat_ovr = 0;
`endif

    for (int k = 0; k < 60 && (m_busy || m_pend != 2'b00 || go_q.size() != 0
                                || done_q.size() != 0); k++) idle(1);
    chk("drain_empty", go_q.size() + done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
